// File: rtl/writeback_stage.sv
// Writeback pipeline register with load-data extraction and result select.
// Optional 64-bit retire counter: define WB_RETIRE_CNT_EN to add retire_count_w.
module writeback_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_m,
    input  logic            stall_w,
    input  logic            flush_w,
    input  logic            reg_write_m,
    input  logic [1:0]      result_src_m,
    input  logic [2:0]      funct3_m,
    input  logic [XLEN-1:0] alu_result_m,
    input  logic [XLEN-1:0] read_data_m,
    input  logic [XLEN-1:0] pc_plus4_m,
    input  logic [XLEN-1:0] imm_ext_m,
    input  logic [RA_W-1:0] rd_m,
    output logic [XLEN-1:0] result_w,
    output logic [RA_W-1:0] rd_w,
    output logic            reg_write_w,
    output logic            valid_w,
    output logic            load_misaligned_w
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [63:0]     retire_count_w
`endif
);
    localparam int OFFW = $clog2(XLEN / 8);

    logic            r_valid;
    logic            r_reg_write;
    logic [1:0]      r_src;
    logic [2:0]      r_funct3;
    logic [XLEN-1:0] r_alu;
    logic [XLEN-1:0] r_rdata;
    logic [XLEN-1:0] r_pc4;
    logic [XLEN-1:0] r_imm;
    logic [RA_W-1:0] r_rd;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_src       <= '0;
            r_funct3    <= '0;
            r_alu       <= '0;
            r_rdata     <= '0;
            r_pc4       <= '0;
            r_imm       <= '0;
            r_rd        <= '0;
        end else if (flush_w) begin
            r_valid <= 1'b0;
        end else if (!stall_w) begin
            r_valid     <= valid_m;
            r_reg_write <= reg_write_m;
            r_src       <= result_src_m;
            r_funct3    <= funct3_m;
            r_alu       <= alu_result_m;
            r_rdata     <= read_data_m;
            r_pc4       <= pc_plus4_m;
            r_imm       <= imm_ext_m;
            r_rd        <= rd_m;
        end
    end

    // Lane shifts: byte by offset, halfword by offset>>1, word by offset>>2 (always 0 on RV32).
    logic [OFFW-1:0] w_off;
    logic [5:0]      w_wsh;
    logic [XLEN-1:0] w_sh_b, w_sh_h, w_sh_w;
    assign w_off  = r_alu[OFFW-1:0];
    assign w_wsh  = (XLEN == 64) ? {w_off[OFFW-1], 5'b00000} : 6'd0;
    assign w_sh_b = r_rdata >> {w_off, 3'b000};
    assign w_sh_h = r_rdata >> {w_off[OFFW-1:1], 4'b0000};
    assign w_sh_w = r_rdata >> w_wsh;

    logic [XLEN-1:0] w_load;
    always_comb begin
        w_load = r_rdata;
        case (r_funct3)
            3'b000: w_load = XLEN'($signed(w_sh_b[7:0]));
            3'b001: w_load = XLEN'($signed(w_sh_h[15:0]));
            3'b010: w_load = XLEN'($signed(w_sh_w[31:0]));
            3'b100: w_load = XLEN'(w_sh_b[7:0]);
            3'b101: w_load = XLEN'(w_sh_h[15:0]);
            3'b110: if (XLEN == 64) w_load = XLEN'(w_sh_w[31:0]);
            default: w_load = r_rdata;
        endcase
    end

    logic w_mis_addr;
    always_comb begin
        w_mis_addr = 1'b0;
        case (r_funct3)
            3'b001, 3'b101: w_mis_addr = r_alu[0];
            3'b010:         w_mis_addr = |r_alu[1:0];
            3'b110:         w_mis_addr = (XLEN == 64) && (|r_alu[1:0]);
            3'b011:         w_mis_addr = (XLEN == 64) && (|r_alu[2:0]);
            default:        w_mis_addr = 1'b0;
        endcase
    end

    always_comb begin
        case (r_src)
            2'b00:   result_w = r_alu;
            2'b01:   result_w = w_load;
            2'b10:   result_w = r_pc4;
            default: result_w = r_imm;
        endcase
    end

    assign load_misaligned_w = r_valid && (r_src == 2'b01) && w_mis_addr;
    assign reg_write_w       = r_valid && r_reg_write && (r_rd != '0) && !load_misaligned_w;
    assign valid_w           = r_valid;
    assign rd_w              = r_rd;

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] r_retire;
    always_ff @(posedge clk) begin
        if (rst)
            r_retire <= '0;
        else if (r_valid && !stall_w && !flush_w && !load_misaligned_w)
            r_retire <= r_retire + 64'd1;
    end
    assign retire_count_w = r_retire;
`endif
endmodule

// File: tb/tb_writeback_stage.sv
// Randomized bench for writeback_stage: RV32 and RV64 instances share stimulus
// and are checked against an arithmetic model of the stage.
module tb_writeback_stage;
    logic        clk = 1'b0;
    logic        rst, valid_m, stall_w, flush_w, reg_write_m;
    logic [1:0]  result_src_m;
    logic [2:0]  funct3_m;
    logic [63:0] alu_m, rdata_m, pc4_m, imm_m;
    logic [4:0]  rd_m;

    logic [31:0] res32;
    logic [63:0] res64;
    logic [4:0]  rd32, rd64;
    logic        rw32, rw64, v32, v64, mis32, mis64;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0] cnt32, cnt64;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    writeback_stage #(.XLEN(32), .RA_W(5)) u32 (
        .clk(clk), .rst(rst), .valid_m(valid_m), .stall_w(stall_w), .flush_w(flush_w),
        .reg_write_m(reg_write_m), .result_src_m(result_src_m), .funct3_m(funct3_m),
        .alu_result_m(alu_m[31:0]), .read_data_m(rdata_m[31:0]), .pc_plus4_m(pc4_m[31:0]),
        .imm_ext_m(imm_m[31:0]), .rd_m(rd_m), .result_w(res32), .rd_w(rd32),
        .reg_write_w(rw32), .valid_w(v32), .load_misaligned_w(mis32)
`ifdef WB_RETIRE_CNT_EN
        , .retire_count_w(cnt32)
`endif
    );

    writeback_stage #(.XLEN(64), .RA_W(5)) u64 (
        .clk(clk), .rst(rst), .valid_m(valid_m), .stall_w(stall_w), .flush_w(flush_w),
        .reg_write_m(reg_write_m), .result_src_m(result_src_m), .funct3_m(funct3_m),
        .alu_result_m(alu_m), .read_data_m(rdata_m), .pc_plus4_m(pc4_m),
        .imm_ext_m(imm_m), .rd_m(rd_m), .result_w(res64), .rd_w(rd64),
        .reg_write_w(rw64), .valid_w(v64), .load_misaligned_w(mis64)
`ifdef WB_RETIRE_CNT_EN
        , .retire_count_w(cnt64)
`endif
    );

    // Model of what the stage currently holds (full 64-bit values; truncated per width).
    logic        m_v, m_rw;
    logic [1:0]  m_src;
    logic [2:0]  m_f3;
    logic [63:0] m_alu, m_rdata, m_pc4, m_imm;
    logic [4:0]  m_rd;
    logic [63:0] m_cnt32, m_cnt64;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] sext(input logic [63:0] v, input int bits);
        logic [63:0] lim;
        lim = 64'd1 << (bits - 1);
        if (v >= lim) return v - (lim << 1);
        return v;
    endfunction

    function automatic int acc_size(input int xl, input logic [2:0] f3);
        case (f3)
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            3'd6:       return (xl == 64) ? 4 : 1;
            3'd3:       return (xl == 64) ? 8 : 1;
            default:    return 1;
        endcase
    endfunction

    function automatic logic ref_mis(input int xl);
        logic [63:0] a;
        a = m_alu;
        return m_v && (m_src == 2'd1) && ((a % acc_size(xl, m_f3)) != 0);
    endfunction

    function automatic logic [63:0] ref_res(input int xl);
        logic [63:0] mask, a, d, off, v;
        mask = (xl == 64) ? '1 : 64'hFFFF_FFFF;
        a    = m_alu & mask;
        d    = m_rdata & mask;
        off  = a % (xl / 8);
        case (m_src)
            2'd0: v = a;
            2'd2: v = m_pc4;
            2'd3: v = m_imm;
            default: begin
                case (m_f3)
                    3'd0: v = sext((d >> (off * 8)) & 64'hFF, 8);
                    3'd1: v = sext((d >> ((off / 2) * 16)) & 64'hFFFF, 16);
                    3'd2: v = sext((d >> ((off / 4) * 32)) & 64'hFFFF_FFFF, 32);
                    3'd4: v = (d >> (off * 8)) & 64'hFF;
                    3'd5: v = (d >> ((off / 2) * 16)) & 64'hFFFF;
                    3'd6: v = (xl == 64) ? ((d >> ((off / 4) * 32)) & 64'hFFFF_FFFF) : d;
                    default: v = d;
                endcase
            end
        endcase
        return v & mask;
    endfunction

    function automatic logic ref_rw(input int xl);
        return m_v && m_rw && (m_rd != 0) && !ref_mis(xl);
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_cnt32 = 0; m_cnt64 = 0;
        end else begin
            if (m_v && !stall_w && !flush_w && !ref_mis(32)) m_cnt32++;
            if (m_v && !stall_w && !flush_w && !ref_mis(64)) m_cnt64++;
        end
        if (rst) begin
            m_v = 0; m_rw = 0; m_src = 0; m_f3 = 0;
            m_alu = 0; m_rdata = 0; m_pc4 = 0; m_imm = 0; m_rd = 0;
        end else if (flush_w) begin
            m_v = 0;
        end else if (!stall_w) begin
            m_v = valid_m; m_rw = reg_write_m; m_src = result_src_m; m_f3 = funct3_m;
            m_alu = alu_m; m_rdata = rdata_m; m_pc4 = pc4_m; m_imm = imm_m; m_rd = rd_m;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".res32"}, {32'd0, res32}, ref_res(32));
        chk({tag, ".res64"}, res64, ref_res(64));
        chk({tag, ".rw32"}, {63'd0, rw32}, {63'd0, ref_rw(32)});
        chk({tag, ".rw64"}, {63'd0, rw64}, {63'd0, ref_rw(64)});
        chk({tag, ".mis32"}, {63'd0, mis32}, {63'd0, ref_mis(32)});
        chk({tag, ".mis64"}, {63'd0, mis64}, {63'd0, ref_mis(64)});
        chk({tag, ".v"}, {62'd0, v32, v64}, {62'd0, m_v, m_v});
        chk({tag, ".rd"}, {54'd0, rd32, rd64}, {54'd0, m_rd, m_rd});
`ifdef WB_RETIRE_CNT_EN
        chk({tag, ".cnt32"}, cnt32, m_cnt32);
        chk({tag, ".cnt64"}, cnt64, m_cnt64);
`endif
    endtask

    task automatic drive(input logic v, input logic rw, input logic [1:0] src,
                         input logic [2:0] f3, input logic [63:0] alu, input logic [63:0] d,
                         input logic [63:0] pc, input logic [63:0] imm, input logic [4:0] rd,
                         input logic st, input logic fl, input logic r);
        valid_m = v; reg_write_m = rw; result_src_m = src; funct3_m = f3;
        alu_m = alu; rdata_m = d; pc4_m = pc; imm_m = imm; rd_m = rd;
        stall_w = st; flush_w = fl; rst = r;
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        m_cnt32 = 0; m_cnt64 = 0;
        drive(1, 1, 0, 0, 64'h77, 0, 0, 0, 5'd3, 0, 0, 1);
        cyc("reset");
        chk("reset.res", {32'd0, res32}, 64'd0);
        chk("reset.rw", {63'd0, rw32}, 64'd0);

        // LB sign-extends the top byte
        drive(1, 1, 2'b01, 3'b000, 64'h1003, 64'h80FF_1234, 0, 0, 5'd5, 0, 0, 0);
        cyc("lb");
        chk("lb.res", {32'd0, res32}, 64'hFFFF_FF80);
        chk("lb.rw", {63'd0, rw32}, 64'd1);

        drive(1, 1, 2'b01, 3'b101, 64'h2002, 64'hBEEF_0000, 0, 0, 5'd6, 0, 0, 0);
        cyc("lhu");
        chk("lhu.res", {32'd0, res32}, 64'h0000_BEEF);

        drive(1, 1, 2'b01, 3'b010, 64'h2001, 64'h1234_5678, 0, 0, 5'd6, 0, 0, 0);
        cyc("lw_mis");
        chk("lw_mis.mis", {63'd0, mis32}, 64'd1);
        chk("lw_mis.rw", {63'd0, rw32}, 64'd0);

        drive(1, 1, 2'b10, 3'b000, 64'h9, 0, 64'h104, 0, 5'd1, 0, 0, 0);
        cyc("pc4");
        chk("pc4.res", {32'd0, res32}, 64'h104);
        chk("pc4.rw", {63'd0, rw32}, 64'd1);
        drive(1, 1, 2'b10, 3'b000, 64'h9, 0, 64'h104, 0, 5'd0, 0, 0, 0);
        cyc("pc4_x0");
        chk("pc4_x0.rw", {63'd0, rw32}, 64'd0);

        // ALU result held through a 3-cycle stall, then flush beats stall
        drive(1, 1, 2'b00, 3'b000, 64'h55, 0, 0, 0, 5'd7, 0, 0, 0);
        cyc("alu");
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 2'b11, 3'b000, 64'h99 + i, 0, 0, 64'hABC, 5'd9, 1, 0, 0);
            cyc("stall");
            chk("stall.res", {32'd0, res32}, 64'h55);
            chk("stall.rw", {63'd0, rw32}, 64'd1);
        end
        drive(1, 1, 2'b11, 3'b000, 64'h99, 0, 0, 64'hABC, 5'd9, 1, 1, 0);
        cyc("flush");
        chk("flush.v", {63'd0, v32}, 64'd0);

        drive(1, 1, 2'b01, 3'b110, 64'h1004, 64'h8000_0001_0000_0000, 0, 0, 5'd4, 0, 0, 0);
        cyc("lwu64");
        chk("lwu64.res", res64, 64'h0000_0000_8000_0001);

        // Retire scenario: 5 valid, one stalled 2 cycles, one misaligned -> 4 retired
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc("rst2");
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, (i == 3) ? 2'b01 : 2'b00, 3'b010, (i == 3) ? 64'h102 : 64'h100,
                  64'h11, 0, 0, 5'd2, 0, 0, 0);
            cyc("ret");
            if (i == 1) begin
                drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
                cyc("ret_st");
                cyc("ret_st");
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("ret_end");
`ifdef WB_RETIRE_CNT_EN
        chk("retire.cnt", cnt32, 64'd4);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        cyc("retire_rst");
        chk("retire_rst.cnt", cnt32, 64'd0);
`endif

        // Random traffic with occasional stall, flush and reset
        for (int n = 0; n < 600; n++) begin
            logic [63:0] a;
            a = {$urandom, $urandom};
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), 2'($urandom_range(0, 3)),
                  3'($urandom_range(0, 7)), a, {$urandom, $urandom}, {$urandom, $urandom},
                  {$urandom, $urandom}, ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 39) == 0);
            cyc("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 Parameter RA_W, default 5, register-address width.
REQ-003 clk  in  1  the single clock; all registers update on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 valid_m  in  1  the memory-stage instruction is valid.
REQ-006 stall_w  in  1  holds the writeback register.
REQ-007 flush_w  in  1  kills the instruction being captured.
REQ-008 reg_write_m  in  1  the instruction writes the register file.
REQ-009 result_src_m  in  2  result select: 00 ALU, 01 load, 10 PC+4, 11 immediate.
REQ-010 funct3_m  in  3  load type.
REQ-011 alu_result_m, read_data_m, pc_plus4_m, imm_ext_m  in  XLEN each  result candidates; alu_result_m is also the load address.
REQ-012 rd_m  in  RA_W  destination register.
REQ-013 result_w  out  XLEN  writeback data.
REQ-014 rd_w  out  RA_W  registered destination.
REQ-015 reg_write_w  out  1  register-file write enable.
REQ-016 valid_w  out  1  the writeback stage holds a valid instruction.
REQ-017 load_misaligned_w  out  1  the held load is misaligned.

Function
REQ-018 On each edge: if flush_w=1, valid_w SHALL become 0 (flush has priority over stall); else if stall_w=0, all _m fields SHALL be captured and valid_w SHALL become valid_m; else all fields SHALL hold.
REQ-019 result_w, reg_write_w and load_misaligned_w SHALL be combinational from the captured fields only; latency from the _m inputs is one cycle, with no path from _m inputs to the outputs.
REQ-020 result_w SHALL select by the captured result_src: ALU result, extracted load data, PC+4, or immediate.
REQ-021 Load extraction uses offset = addr[log2(XLEN/8)-1:0]; byte lane = offset, halfword lane = offset>>1, word lane = offset>>2.
REQ-022 Load types by funct3: 000 LB sign-extended, 001 LH sign-extended, 010 LW sign-extended to XLEN, 100 LBU zero-extended, 101 LHU zero-extended.
REQ-023 For XLEN=64, funct3 011 SHALL select LD (full doubleword) and 110 SHALL select LWU (zero-extended word).
REQ-024 Any other funct3, including 011 and 110 when XLEN=32, SHALL pass read_data unmodified.
REQ-025 load_misaligned_w SHALL be 1 only when valid_w=1, the captured result_src=01, and the address is not a multiple of the access size (H: 2, W: 4, D: 8).
REQ-026 reg_write_w SHALL equal valid_w AND the captured reg_write AND (rd_w != 0) AND NOT load_misaligned_w.
REQ-027 While stall_w=1, the outputs SHALL remain stable and reg_write_w SHALL re-assert every cycle (an idempotent write).

Reset
REQ-028 With rst=1 at an edge, valid_w, rd_w and all captured fields SHALL be 0, so result_w=0, reg_write_w=0 and load_misaligned_w=0.
REQ-029 rst SHALL override flush_w and stall_w, and a reset mid-stall SHALL discard the held instruction.

Configuration
REQ-030 When macro WB_RETIRE_CNT_EN is defined, the block SHALL add output retire_count_w (64 bits, reset 0).
REQ-031 retire_count_w SHALL increment at each edge where valid_w=1, stall_w=0, flush_w=0 and load_misaligned_w=0, and SHALL wrap from all-ones to 0.
REQ-032 When WB_RETIRE_CNT_EN is undefined, the port and counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-033 XLEN=32; LB, addr=0x1003, read_data=0x80FF_1234 -> next cycle result_w=0xFFFF_FF80, reg_write_w=1.
REQ-034 LHU, addr=0x2002, read_data=0xBEEF_0000 -> result_w=0x0000_BEEF; then LW at addr=0x2001 -> load_misaligned_w=1, reg_write_w=0.
REQ-035 result_src=10, pc_plus4=0x0000_0104, rd=1 -> result_w=0x104; same instruction with rd=0 -> reg_write_w=0.
REQ-036 Valid ALU op (result 0x55) captured, then stall_w=1 for 3 cycles with new _m values -> result_w stays 0x55; then stall_w=1 and flush_w=1 together -> valid_w=0 next cycle.
REQ-037 XLEN=64; LWU, addr offset 4, read_data=0x8000_0001_0000_0000 -> result_w=0x0000_0000_8000_0001.
REQ-038 WB_RETIRE_CNT_EN defined; 5 valid instructions, one stalled for 2 cycles, one misaligned -> retire_count_w=4; then rst=1 -> 0.
